// File: rtl/acs_array_if.sv
// Valid/ready bus between the branch-metric unit, the ACS array and the
// traceback unit; the master side produces branch metrics and consumes results.
interface acs_array_if #(
  parameter int K    = 3,
  parameter int BM_W = 2,
  parameter int PM_W = 8
) ();
  localparam int N_STATES = 1 << (K - 1);

  logic                       start_i;
  logic                       in_valid_i;
  logic                       in_ready_o;
  logic [4*BM_W-1:0]          bm_i;
  logic                       out_valid_o;
  logic                       out_ready_i;
  logic [N_STATES-1:0]        dec_o;
  logic [N_STATES*PM_W-1:0]   pm_o;
  logic [N_STATES-1:0]        pm_valid_o;
  logic [K-2:0]               best_state_o;

  modport master (
    output start_i, in_valid_i, bm_i, out_ready_i,
    input  in_ready_o, out_valid_o, dec_o, pm_o, pm_valid_o, best_state_o
  );

  modport slave (
    input  start_i, in_valid_i, bm_i, out_ready_i,
    output in_ready_o, out_valid_o, dec_o, pm_o, pm_valid_o, best_state_o
  );
endinterface

// File: rtl/acs_array.sv
// Add-compare-select array: one full trellis step per accepted beat, with
// saturating adds, min-normalised path metrics and survivor decisions.
module acs_array #(
  parameter int           K    = 3,
  parameter logic [K-1:0] G0   = 3'b111,
  parameter logic [K-1:0] G1   = 3'b101,
  parameter int           BM_W = 2,
  parameter int           PM_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  acs_array_if.slave  bus
);
  localparam int N_STATES = 1 << (K - 1);
  localparam int S_W      = K - 1;

  logic                 out_valid_q;
  logic [N_STATES-1:0]  dec_q;
  logic [N_STATES-1:0]  valid_q;
  logic [S_W-1:0]       best_q;
  logic [PM_W-1:0]      pm_q [N_STATES];

  logic                 accept;
  logic [PM_W-1:0]      src_pm [N_STATES];
  logic [N_STATES-1:0]  src_valid;
  logic [PM_W-1:0]      cost0 [N_STATES];
  logic [PM_W-1:0]      cost1 [N_STATES];
  logic [PM_W-1:0]      cost [N_STATES];
  logic [PM_W-1:0]      norm [N_STATES];
  logic [N_STATES-1:0]  sel;
  logic [N_STATES-1:0]  new_valid;
  logic [PM_W-1:0]      min_cost;
  logic [S_W-1:0]       best;
  logic [N_STATES*PM_W-1:0] pm_flat;

  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a,
                                              input logic [BM_W-1:0] b);
    logic [PM_W:0] sum;
    sum = {1'b0, a} + {{(PM_W + 1 - BM_W){1'b0}}, b};
    return sum[PM_W] ? {PM_W{1'b1}} : sum[PM_W-1:0];
  endfunction

  function automatic logic [1:0] symbol(input logic [K-1:0] r);
    return {^(r & G0), ^(r & G1)};
  endfunction

  assign accept         = bus.in_valid_i && bus.in_ready_o;
  assign bus.in_ready_o = !out_valid_q || bus.out_ready_i;

  // A frame start replaces the registered history with the all-zero origin.
  always_comb begin
    for (int s = 0; s < N_STATES; s++) begin
      src_pm[s] = bus.start_i ? '0 : pm_q[s];
    end
    src_valid = bus.start_i ? N_STATES'(1) : valid_q;
  end

  always_comb begin
    sel       = '0;
    new_valid = '0;
    for (int s = 0; s < N_STATES; s++) begin
      logic [S_W-1:0] p0;
      logic [S_W-1:0] p1;
      logic [1:0]     sym0;
      logic [1:0]     sym1;
      p0       = S_W'(s >> 1);
      p1       = p0 | S_W'(N_STATES / 2);
      sym0     = symbol({1'b0, S_W'(s)});
      sym1     = symbol({1'b1, S_W'(s)});
      cost0[s] = sat_add(src_pm[p0], bus.bm_i[sym0*BM_W +: BM_W]);
      cost1[s] = sat_add(src_pm[p1], bus.bm_i[sym1*BM_W +: BM_W]);
      cost[s]  = '0;
      case ({src_valid[p1], src_valid[p0]})
        2'b01: cost[s] = cost0[s];
        2'b10: begin
          sel[s]  = 1'b1;
          cost[s] = cost1[s];
        end
        2'b11: begin
          sel[s]  = cost0[s] > cost1[s];
          cost[s] = sel[s] ? cost1[s] : cost0[s];
        end
        default: cost[s] = '0;
      endcase
      new_valid[s] = src_valid[p0] | src_valid[p1];
    end
  end

  // Descending scan so the lowest-index zero metric wins as best state.
  always_comb begin
    min_cost = '1;
    best     = '0;
    for (int s = 0; s < N_STATES; s++) begin
      if (new_valid[s] && cost[s] < min_cost) min_cost = cost[s];
    end
    for (int s = 0; s < N_STATES; s++) begin
      norm[s] = new_valid[s] ? cost[s] - min_cost : '0;
    end
    for (int s = N_STATES - 1; s >= 0; s--) begin
      if (new_valid[s] && norm[s] == '0) best = S_W'(s);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      dec_q       <= '0;
      valid_q     <= N_STATES'(1);
      best_q      <= '0;
      for (int s = 0; s < N_STATES; s++) pm_q[s] <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      dec_q       <= sel;
      valid_q     <= new_valid;
      best_q      <= best;
      for (int s = 0; s < N_STATES; s++) pm_q[s] <= norm[s];
    end else if (bus.out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  always_comb begin
    pm_flat = '0;
    for (int s = 0; s < N_STATES; s++) pm_flat[s*PM_W +: PM_W] = pm_q[s];
  end

  assign bus.out_valid_o  = out_valid_q;
  assign bus.dec_o        = dec_q;
  assign bus.pm_o         = pm_flat;
  assign bus.pm_valid_o   = valid_q;
  assign bus.best_state_o = best_q;
endmodule

// File: doc/acs_array.md
Name: acs_array

Overview:
- Parametrised add-compare-select array for the Viterbi decoder: one full trellis step per accepted input beat, with all N_STATES ACS units working in parallel.
- Holds the path-metric register bank and per-state validity, and normalises metrics by subtracting the per-step minimum.
- Emits per-state survivor decisions, the normalised metrics and the best state to the traceback unit.
- Sits between the branch-metric unit (upstream) and the survivor memory/traceback unit (downstream), using valid/ready handshakes on both sides.

Parameters:
- K, 3, constraint length; N_STATES = 2^(K-1).
- G0, 3'b111, generator polynomial for code bit c0 (K bits).
- G1, 3'b101, generator polynomial for code bit c1 (K bits).
- BM_W, 2, branch-metric width.
- PM_W, 8, path-metric width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  frame start; qualified by an accepted beat.
- in_valid_i  in  1  branch metrics valid.
- in_ready_o  out  1  array can accept a beat.
- bm_i  in  4*BM_W  branch metric per expected symbol; slice index = {c0,c1}.
- out_valid_o  out  1  step result valid.
- out_ready_i  in  1  downstream accepts the result.
- dec_o  out  N_STATES  survivor bit per state; 1 = upper predecessor chosen.
- pm_o  out  N_STATES*PM_W  normalised path metrics; state s at slice s.
- pm_valid_o  out  N_STATES  per-state reachability.
- best_state_o  out  K-1  index of the minimum valid metric.

Behaviour:
- Reset, or any time rst_n is low (asynchronous):
  - out_valid_o=0, dec_o=0, pm_o=0, best_state_o=0.
  - pm_valid_o = only bit 0 set.
  - Internal metrics equal the output registers.
- Handshake:
  - in_ready_o = !out_valid_o || out_ready_i.
  - A beat is accepted when in_valid_i && in_ready_o.
  - Latency: 1 cycle. The result is registered on the accepting edge, and out_valid_o rises the next cycle.
  - Outputs hold stable while out_valid_o && !out_ready_i.
  - Back-to-back throughput is 1 beat/cycle when out_ready_i=1.
- Source metrics for a step:
  - Normal beat: the current registered metrics and validity.
  - start_i on an accepted beat: metrics are 0 and only state 0 is valid. The step is computed from this, ignoring registered history.
  - start_i without acceptance has no effect.
- Trellis, for each state s:
  - Predecessors: p0 = s>>1 and p1 = (s>>1) | N_STATES/2.
  - Encoder register r = {p[K-2], s}, K bits.
  - Expected symbol: c0 = ^(r & G0), c1 = ^(r & G1); branch metric = bm_i slice {c0,c1}.
- Add:
  - cost_j = pm[pj] + bm_j, computed at PM_W+1 bits and saturated to 2^PM_W - 1.
- Compare/select:
  - Only p1 valid: sel=1. Only p0 valid: sel=0.
  - Both valid: sel = (cost_0 > cost_1); ties select 0.
  - Neither valid: state invalid, sel=0, cost=0.
  - new_valid[s] = valid[p0] | valid[p1].
- Normalise:
  - m = minimum of costs over new-valid states.
  - Each valid state stores cost - m; invalid states store 0.
  - At least one state is always valid, so m is well-defined.
- best_state_o: index of the valid state with minimum stored metric (i.e. 0); lowest index wins ties.
- dec_o[s] = sel of state s.
- Registered state is updated only on accepted beats.
- A reset asserted mid-frame discards all history; the first post-reset beat behaves as if start_i were set.

Test Plan (K=3, G0=7, G1=5, BM_W=2, PM_W=8):
- Reset, then one beat with bm_i={bm3=2, bm2=1, bm1=1, bm0=0}, out_ready_i=1 -> next cycle:
  - out_valid_o=1, pm_valid_o=4'b0011, pm[0]=0, pm[1]=2, dec_o=0, best_state_o=0.
- Feed 8 all-zero-received beats (same bm_i) -> state 0 stays at metric 0 and best_state_o=0 throughout; all four states valid from beat 2 onward; no metric exceeds 6.
- Hold out_ready_i=0 with in_valid_i=1 for 3 cycles -> in_ready_o=0, all outputs frozen, metrics unchanged; on release, exactly one beat is accepted per cycle.
- Tie case: both predecessors valid with equal cost -> dec_o bit = 0.
- Saturation: force a stored metric of 255 plus bm=2 -> cost clamps to 255 before normalisation.
- Assert start_i mid-stream -> result equals the first-beat result of a fresh frame.
- Assert rst_n low mid-stream -> result equals the first-beat result of a fresh frame, and outputs return to reset values asynchronously.
